// File: rtl/chan_mux_seq.sv
// rtl/chan_mux_seq.sv - CHANNELS-to-1 word mux with direct/scan modes and a valid/ready output slot
module chan_mux_seq #(
    parameter  int WIDTH    = 8,
    parameter  int CHANNELS = 8,
    localparam int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]          sel,
    input  logic                      mode,
    input  logic                      load,
    input  logic                      start,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_sel,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      sel_err,
    output logic                      busy,
    output logic                      scan_done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Last legal channel index, and the channel count widened by one bit so that
    // an out-of-range select can be detected even when CHANNELS == 2**SEL_W.
    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(CHANNELS - 1);
    localparam logic [SEL_W:0]   CH_LIM   = (SEL_W + 1)'(CHANNELS);

    state_t           state_q;
    logic [SEL_W-1:0] idx_q;
    logic [WIDTH-1:0] out_data_q;
    logic [SEL_W-1:0] out_sel_q;
    logic             out_valid_q;
    logic             sel_err_q;
    logic             scan_done_q;

    logic [WIDTH-1:0] sel_word;
    logic [WIDTH-1:0] idx_word;
    logic             sel_oor;
    logic             slot_free;

    // The slot can take a new word when it is empty or its word leaves this cycle,
    // which lets a capture and a handshake overlap without a bubble.
    assign slot_free = !out_valid_q || out_ready;
    assign sel_oor   = ({1'b0, sel} >= CH_LIM);

    // Candidate words for direct select and scan index; a select that matches no
    // channel leaves the word at zero, which is what an out-of-range capture holds.
    always_comb begin
        sel_word = '0;
        idx_word = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (sel == SEL_W'(i)) begin
                sel_word = in_data[i*WIDTH +: WIDTH];
            end
            if (idx_q == SEL_W'(i)) begin
                idx_word = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Mode FSM plus the registered output slot; a capture in the same cycle as a
    // handshake overrides the slot-empty update below it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            out_valid_q <= 1'b0;
            sel_err_q   <= 1'b0;
            scan_done_q <= 1'b0;
        end else begin
            scan_done_q <= 1'b0;
            if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (!mode) begin
                        if (load && slot_free) begin
                            out_data_q  <= sel_word;
                            out_sel_q   <= sel;
                            out_valid_q <= 1'b1;
                            sel_err_q   <= sel_oor;
                        end
                    end else if (start) begin
                        state_q <= SCAN;
                        idx_q   <= '0;
                    end
                end

                SCAN: begin
                    if (slot_free) begin
                        out_data_q  <= idx_word;
                        out_sel_q   <= idx_q;
                        out_valid_q <= 1'b1;
                        sel_err_q   <= 1'b0;
                        if (idx_q == LAST_IDX) begin
                            state_q <= DRAIN;
                        end else begin
                            idx_q <= idx_q + SEL_W'(1);
                        end
                    end
                end

                DRAIN: begin
                    if (out_valid_q && out_ready) begin
                        state_q     <= IDLE;
                        scan_done_q <= 1'b1;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;
    assign out_valid = out_valid_q;
    assign sel_err   = sel_err_q;
    assign scan_done = scan_done_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_chan_mux_seq.sv
// tb/tb_chan_mux_seq.sv - scoreboard bench for chan_mux_seq (8-channel and 6-channel instances)
module tb_chan_mux_seq;

    typedef struct {
        logic [7:0] d;
        logic [2:0] s;
        logic       e;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [63:0] in8;
    logic [2:0]  sel8   = '0;
    logic        mode8  = 1'b0;
    logic        load8  = 1'b0;
    logic        start8 = 1'b0;
    logic        rdy8   = 1'b1;
    logic [7:0]  o8_data;
    logic [2:0]  o8_sel;
    logic        o8_valid, o8_err, o8_busy, o8_done;

    logic [47:0] in6;
    logic [2:0]  sel6   = '0;
    logic        load6  = 1'b0;
    logic        rdy6   = 1'b1;
    logic [7:0]  o6_data;
    logic [2:0]  o6_sel;
    logic        o6_valid, o6_err, o6_busy, o6_done;

    exp_t q8[$];
    exp_t q6[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_acc8   = 0;
    int   n_done8  = 0;

    always #5 clk = ~clk;

    chan_mux_seq #(.WIDTH(8), .CHANNELS(8)) u8 (
        .clk(clk), .rst(rst), .in_data(in8), .sel(sel8), .mode(mode8),
        .load(load8), .start(start8), .out_data(o8_data), .out_sel(o8_sel),
        .out_valid(o8_valid), .out_ready(rdy8), .sel_err(o8_err),
        .busy(o8_busy), .scan_done(o8_done)
    );

    chan_mux_seq #(.WIDTH(8), .CHANNELS(6)) u6 (
        .clk(clk), .rst(rst), .in_data(in6), .sel(sel6), .mode(1'b0),
        .load(load6), .start(1'b0), .out_data(o6_data), .out_sel(o6_sel),
        .out_valid(o6_valid), .out_ready(rdy6), .sel_err(o6_err),
        .busy(o6_busy), .scan_done(o6_done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_scan8();
        for (int i = 0; i < 8; i++) begin
            q8.push_back('{d: 8'h10 + 8'(i), s: 3'(i), e: 1'b0});
        end
    endtask

    // Monitor for the 8-channel instance: held word must match the queue head,
    // and the head is retired only on the accepting handshake.
    always @(negedge clk) begin
        if (!rst) begin
            if (o8_done) begin
                n_done8++;
                chk("dut8_busy_at_done", 32'(o8_busy), 32'd0);
            end
            if (o8_valid) begin
                if (q8.size() == 0) begin
                    chk("dut8_unexpected_word_sel", 32'(o8_sel), 32'hffff_ffff);
                end else begin
                    chk("dut8_data", 32'(o8_data), 32'(q8[0].d));
                    chk("dut8_sel", 32'(o8_sel), 32'(q8[0].s));
                    chk("dut8_err", 32'(o8_err), 32'(q8[0].e));
                    if (rdy8) begin
                        void'(q8.pop_front());
                        n_acc8++;
                    end
                end
            end
        end
    end

    // Monitor for the 6-channel instance.
    always @(negedge clk) begin
        if (!rst && o6_valid) begin
            if (q6.size() == 0) begin
                chk("dut6_unexpected_word_sel", 32'(o6_sel), 32'hffff_ffff);
            end else begin
                chk("dut6_data", 32'(o6_data), 32'(q6[0].d));
                chk("dut6_sel", 32'(o6_sel), 32'(q6[0].s));
                chk("dut6_err", 32'(o6_err), 32'(q6[0].e));
                if (rdy6) void'(q6.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        logic [2:0] ld6_sel [4];
        exp_t       ld6_exp [4];

        for (int i = 0; i < 8; i++) in8[i*8 +: 8] = 8'h10 + 8'(i);
        for (int i = 0; i < 6; i++) in6[i*8 +: 8] = 8'h30 + 8'(i);

        tick();
        tick();
        rst = 1'b0;
        chk("reset_valid", 32'(o8_valid), 32'd0);
        chk("reset_data", 32'(o8_data), 32'd0);
        chk("reset_sel", 32'(o8_sel), 32'd0);
        chk("reset_err", 32'(o8_err), 32'd0);
        chk("reset_busy", 32'(o8_busy), 32'd0);
        chk("reset_done", 32'(o8_done), 32'd0);
        chk("reset_valid6", 32'(o6_valid), 32'd0);

        // Direct capture of channel 5
        sel8 = 3'd5; load8 = 1'b1;
        q8.push_back('{d: 8'h15, s: 3'd5, e: 1'b0});
        tick();
        load8 = 1'b0;
        chk("direct_valid", 32'(o8_valid), 32'd1);
        tick();
        chk("direct_valid_drop", 32'(o8_valid), 32'd0);

        // Backpressure: second load ignored, then back-to-back capture on ready
        rdy8 = 1'b0; sel8 = 3'd2; load8 = 1'b1;
        q8.push_back('{d: 8'h12, s: 3'd2, e: 1'b0});
        tick();
        sel8 = 3'd6;
        tick();
        tick();
        chk("bp_hold_data", 32'(o8_data), 32'h12);
        rdy8 = 1'b1;
        q8.push_back('{d: 8'h16, s: 3'd6, e: 1'b0});
        tick();
        load8 = 1'b0;
        chk("bp_no_bubble_valid", 32'(o8_valid), 32'd1);
        chk("bp_no_bubble_data", 32'(o8_data), 32'h16);
        tick();
        chk("bp_drain_valid", 32'(o8_valid), 32'd0);

        // Out-of-range selects on the 6-channel instance
        ld6_sel = '{3'd7, 3'd3, 3'd6, 3'd0};
        ld6_exp = '{'{d: 8'h00, s: 3'd7, e: 1'b1}, '{d: 8'h33, s: 3'd3, e: 1'b0},
                    '{d: 8'h00, s: 3'd6, e: 1'b1}, '{d: 8'h30, s: 3'd0, e: 1'b0}};
        for (int i = 0; i < 4; i++) begin
            sel6 = ld6_sel[i]; load6 = 1'b1;
            q6.push_back(ld6_exp[i]);
            tick();
        end
        load6 = 1'b0;
        chk("oor_last_err", 32'(o6_err), 32'd0);
        tick();
        chk("oor_valid_drop", 32'(o6_valid), 32'd0);

        // Scan with ready held high
        mode8 = 1'b1; start8 = 1'b1;
        push_scan8();
        tick();
        start8 = 1'b0;
        chk("scan_busy_start", 32'(o8_busy), 32'd1);
        chk("scan_gap_valid", 32'(o8_valid), 32'd0);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("scan_beat_sel", 32'(o8_sel), 32'(i));
            chk("scan_beat_valid", 32'(o8_valid), 32'd1);
            chk("scan_beat_busy", 32'(o8_busy), 32'd1);
        end
        tick();
        chk("scan_done_pulse", 32'(o8_done), 32'd1);
        chk("scan_done_busy", 32'(o8_busy), 32'd0);
        chk("scan_done_valid", 32'(o8_valid), 32'd0);
        tick();
        chk("scan_done_single", 32'(o8_done), 32'd0);
        chk("scan_done_count", 32'(n_done8), 32'd1);

        // Scan with ready toggling and ignored load/start/mode activity
        start8 = 1'b1;
        push_scan8();
        tick();
        start8 = 1'b0;
        for (int c = 0; c < 100 && n_done8 < 2; c++) begin
            rdy8 = ~rdy8;
            if (o8_busy) begin
                load8  = 1'b1;
                start8 = c[0];
                mode8  = c[1];
                sel8   = 3'(c);
            end else begin
                load8  = 1'b0;
                start8 = 1'b0;
            end
            tick();
        end
        load8 = 1'b0; start8 = 1'b0; mode8 = 1'b1; rdy8 = 1'b1;
        tick();
        chk("stall_done_count", 32'(n_done8), 32'd2);
        chk("stall_queue_empty", 32'(q8.size()), 32'd0);
        chk("stall_idle_valid", 32'(o8_valid), 32'd0);

        // Reset in the middle of a scan
        base = n_acc8;
        start8 = 1'b1;
        push_scan8();
        tick();
        start8 = 1'b0;
        for (int c = 0; c < 20 && n_acc8 < base + 4; c++) tick();
        chk("midscan_accepted", 32'(n_acc8 - base), 32'd4);
        rst = 1'b1;
        q8.delete();
        tick();
        rst = 1'b0;
        chk("midscan_valid", 32'(o8_valid), 32'd0);
        chk("midscan_busy", 32'(o8_busy), 32'd0);
        chk("midscan_data", 32'(o8_data), 32'd0);
        chk("midscan_done", 32'(o8_done), 32'd0);
        tick();
        tick();
        chk("midscan_no_done", 32'(n_done8), 32'd2);

        start8 = 1'b1;
        push_scan8();
        tick();
        start8 = 1'b0;
        for (int c = 0; c < 40 && n_done8 < 3; c++) tick();
        chk("rescan_done_count", 32'(n_done8), 32'd3);
        chk("rescan_queue_empty", 32'(q8.size()), 32'd0);
        chk("final_queue6_empty", 32'(q6.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
